mp3_mem_responder: RTL and testbench
====================================

Name: mp3_mem_responder

Overview:
- Dual-port memory responder model for the mp3 core's memory buses.
- Port A: read-only instruction fetch. Port B: data read/write with byte mask.
- Answers core requests from an internal word array after a programmable per-port latency. Used in place of ideal zero-wait memory for stall and latency testing.

Parameters:
IDX_WIDTH, 8, word-index bits; array depth = 2**IDX_WIDTH 16-bit words
LATENCY_A, 2, port A cycles from acceptance to resp_a (legal 1..15)
LATENCY_B, 3, port B cycles from acceptance to resp_b (legal 1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
read_a  input  1  port A read request, held until resp_a
address_a  input  16  port A byte address
resp_a  output  1  port A completion pulse
rdata_a  output  16  port A read data
read_b  input  1  port B read request
write_b  input  1  port B write request
wmask_b  input  2  byte enables; [0]=bits 7:0, [1]=bits 15:8
address_b  input  16  port B byte address
wdata_b  input  16  port B write data
resp_b  output  1  port B completion pulse
rdata_b  output  16  port B read data
err_b  output  1  sticky: read_b and write_b both seen high at acceptance

Behaviour:
- Reset (async assert, sync release): resp_a=0, resp_b=0, rdata_a=0, rdata_b=0, err_b=0. Both FSMs go to IDLE and counters clear. A pending write is dropped. Array contents are not reset.
- Word index = address[IDX_WIDTH:1]. Bit 0 is ignored. Upper bits are ignored, so addresses wrap.
- Each port has an independent FSM: IDLE -> BUSY -> RESP -> GAP -> IDLE.
- IDLE: a request high at rising edge t0 is accepted.
  - Address is latched; for port B, wdata, wmask and op are also latched.
  - Counter loads LATENCY-1. Next state: BUSY if LATENCY>1, else RESP.
  - Later changes on the request inputs are ignored until GAP ends.
- BUSY: counter decrements each edge; at 0 go to RESP.
  - Net effect: resp is high during the cycle after edge t0+LATENCY-1, i.e. rises LATENCY cycles after the request is first sampled.
- On the edge entering RESP:
  - Read: rdata_x <= array[latched idx].
  - Write: the array is updated on the enabled bytes only.
  - wmask 2'b00: no change, but resp is still given.
- RESP: resp_x=1 for exactly one cycle. rdata_x holds its value until the next read completion on that port; writes leave rdata_b unchanged.
- GAP: one cycle, requests ignored, so a still-held request is not serviced twice. Minimum back-to-back spacing is LATENCY+2 cycles.
- If a request drops mid-BUSY, the transaction still completes and pulses resp (no abort).
- read_b and write_b both high at acceptance: treated as write, and err_b is set until reset.
- Cross-port collision, same index, port-B write and port-A read committing on the same edge: port A returns the pre-write data. The write is visible to any later read.
- Both ports may complete on the same edge; the two are fully independent.

Test Plan:
- Reset, then port B write 16'hBEEF to 16'h0010 with wmask 11; port A read 16'h0010 → resp_b exactly 3 cycles after acceptance, one cycle wide; resp_a 2 cycles after acceptance; rdata_a=16'hBEEF.
- Byte mask: write 16'h1234 with mask 11, then 16'hAB00 with mask 10, then read on B → 16'hAB34. A write with mask 00 still pulses resp_b and leaves data 16'hAB34.
- Held request: keep read_a high for 12 cycles → resp_a pulses at cycles 2, 6 and 10 (period LATENCY_A+2); never two adjacent pulses.
- Wrap/alignment with IDX_WIDTH=8: write 16'h5A5A to 16'h0201, then read 16'h0000 → 16'h5A5A. Read at 16'h0001 → same data.
- Collision: port-B write 16'h0F0F (LATENCY_B=2) and port-A read (LATENCY_A=2) to the same index, accepted on the same edge → rdata_a returns old data; the next port-A read returns 16'h0F0F.
- Reset mid-BUSY of a port-B write: pulse rst_n low asynchronously → resp_b=0 immediately and no pulse follows; a later read shows unchanged memory. Both read_b and write_b high → write performed and err_b=1 until reset.

Source files
------------

// File: rtl/mp3_mem_responder.sv
// mp3_mem_responder
//   Dual-port memory responder for the mp3 core's memory buses. It answers
//   requests from an internal array of 16-bit words after a fixed per-port
//   latency, so the core's stall and latency handling can be exercised.
//   Port A is read-only (instruction fetch). Port B reads and writes (data),
//   and its writes are byte-masked.
//
// Parameters
//   IDX_WIDTH  word-index bits; the array holds 2**IDX_WIDTH words
//   LATENCY_A  cycles from port A acceptance to resp_a (1..15)
//   LATENCY_B  cycles from port B acceptance to resp_b (1..15)
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   read_a, address_a     port A request and byte address
//   resp_a, rdata_a       port A completion pulse and read data
//   read_b, write_b       port B read/write requests
//   wmask_b               byte enables: [0] -> bits 7:0, [1] -> bits 15:8
//   address_b, wdata_b    port B byte address and write data
//   resp_b, rdata_b       port B completion pulse and read data
//   err_b                 sticky flag: read_b and write_b both high at acceptance
//
// Handshake: a request is sampled only while the port is IDLE. After
// acceptance the request inputs are ignored until the GAP cycle ends.
// resp_x is high for exactly one cycle. The state sequence per port is
// IDLE -> BUSY -> RESP -> GAP -> IDLE. BUSY is skipped when the latency is 1.
module mp3_mem_responder #(
    parameter int IDX_WIDTH = 8,
    parameter int LATENCY_A = 2,
    parameter int LATENCY_B = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_a,
    input  logic [15:0] address_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        err_b
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    logic [15:0] mem [DEPTH];

    // Byte bit 0 and the bits above the index are ignored on purpose, so
    // addresses wrap around the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_a, address_b};

    // ---------------- port A ----------------
    state_t               state_a, next_a;
    logic [3:0]           cnt_a;
    logic [IDX_WIDTH-1:0] idx_a_q, idx_a;
    logic                 accept_a, commit_a;

    always_comb begin
        next_a   = state_a;
        accept_a = 1'b0;
        case (state_a)
            IDLE: if (read_a) begin
                accept_a = 1'b1;
                next_a   = (LATENCY_A > 1) ? BUSY : RESP;
            end
            // The counter was loaded with LATENCY-1. Leaving on the edge
            // where it still reads 1 puts RESP on edge t0+LATENCY-1.
            BUSY:    if (cnt_a == 4'd1) next_a = RESP;
            RESP:    next_a = GAP;
            GAP:     next_a = IDLE;
            default: next_a = IDLE;
        endcase
        commit_a = (next_a == RESP) && (state_a != RESP);
    end

    // With latency 1 the commit happens on the accepting edge, before the
    // latch holds anything, so the live address is used while IDLE.
    assign idx_a  = (state_a == IDLE) ? address_a[IDX_WIDTH:1] : idx_a_q;
    assign resp_a = (state_a == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_a <= IDLE;
            cnt_a   <= '0;
            idx_a_q <= '0;
            rdata_a <= '0;
        end else begin
            state_a <= next_a;
            if (accept_a) begin
                cnt_a   <= 4'(LATENCY_A - 1);
                idx_a_q <= address_a[IDX_WIDTH:1];
            end else if (state_a == BUSY) begin
                cnt_a <= cnt_a - 4'd1;
            end
            if (commit_a) rdata_a <= mem[idx_a];
        end
    end

    // ---------------- port B ----------------
    state_t               state_b, next_b;
    logic [3:0]           cnt_b;
    logic [IDX_WIDTH-1:0] idx_b_q, idx_b;
    logic                 wr_b_q, wr_b;
    logic [1:0]           mask_b_q, mask_b;
    logic [15:0]          data_b_q, data_b;
    logic                 accept_b, commit_b;

    always_comb begin
        next_b   = state_b;
        accept_b = 1'b0;
        case (state_b)
            IDLE: if (read_b || write_b) begin
                accept_b = 1'b1;
                next_b   = (LATENCY_B > 1) ? BUSY : RESP;
            end
            BUSY:    if (cnt_b == 4'd1) next_b = RESP;
            RESP:    next_b = GAP;
            GAP:     next_b = IDLE;
            default: next_b = IDLE;
        endcase
        commit_b = (next_b == RESP) && (state_b != RESP);
    end

    // When both request lines are high, the request is treated as a write.
    assign idx_b  = (state_b == IDLE) ? address_b[IDX_WIDTH:1] : idx_b_q;
    assign wr_b   = (state_b == IDLE) ? write_b : wr_b_q;
    assign mask_b = (state_b == IDLE) ? wmask_b : mask_b_q;
    assign data_b = (state_b == IDLE) ? wdata_b : data_b_q;
    assign resp_b = (state_b == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_b  <= IDLE;
            cnt_b    <= '0;
            idx_b_q  <= '0;
            wr_b_q   <= 1'b0;
            mask_b_q <= '0;
            data_b_q <= '0;
            rdata_b  <= '0;
            err_b    <= 1'b0;
        end else begin
            state_b <= next_b;
            if (accept_b) begin
                cnt_b    <= 4'(LATENCY_B - 1);
                idx_b_q  <= address_b[IDX_WIDTH:1];
                wr_b_q   <= write_b;
                mask_b_q <= wmask_b;
                data_b_q <= wdata_b;
                if (read_b && write_b) err_b <= 1'b1;
            end else if (state_b == BUSY) begin
                cnt_b <= cnt_b - 4'd1;
            end
            if (commit_b && !wr_b) rdata_b <= mem[idx_b];
        end
    end

    // The array is not reset. The write lands on the same edge as a port A
    // read of the same word, and non-blocking update order gives port A the
    // old data. The rst_n term stops a latency-1 write while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && commit_b && wr_b) begin
            if (mask_b[0]) mem[idx_b][7:0]  <= data_b[7:0];
            if (mask_b[1]) mem[idx_b][15:8] <= data_b[15:8];
        end
    end

endmodule

// File: tb/tb_mp3_mem_responder.sv
// tb_mp3_mem_responder
//   Directed bench for mp3_mem_responder with the default latencies
//   (A = 2, B = 3). A transaction-level model runs next to the DUT. It tracks
//   acceptance times, due edges and a shadow word array, and a compare process
//   checks every DUT output against it on each falling edge. Hand-computed
//   literal checks pin the latency, the data values and the pulse spacing.
module tb_mp3_mem_responder;

    localparam int LA = 2;
    localparam int LB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_a = 1'b0;
    logic [15:0] address_a = '0;
    logic        resp_a;
    logic [15:0] rdata_a;
    logic        read_b = 1'b0;
    logic        write_b = 1'b0;
    logic [1:0]  wmask_b = '0;
    logic [15:0] address_b = '0;
    logic [15:0] wdata_b = '0;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        err_b;

    mp3_mem_responder #(.IDX_WIDTH(8), .LATENCY_A(LA), .LATENCY_B(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b), .err_b(err_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [15:0] mem_m [256];
    bit          mem_k [256];
    int          e;
    bit          pa, pb;
    int          due_a, free_a, due_b, free_b;
    logic [7:0]  ia, ib;
    bit          wb;
    logic [1:0]  mb;
    logic [15:0] db;
    logic        exp_resp_a = 1'b0, exp_resp_b = 1'b0, exp_err_b = 1'b0;
    logic [15:0] exp_rd_a = '0, exp_rd_b = '0;
    bit          ka = 1'b1, kb = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; pa = 0; pb = 0; free_a = 0; free_b = 0;
            exp_resp_a = 0; exp_resp_b = 0; exp_err_b = 0;
            exp_rd_a = '0; exp_rd_b = '0; ka = 1; kb = 1;
        end else begin
            e = e + 1;
            exp_resp_a = 0;
            exp_resp_b = 0;
            if (!pa && e >= free_a && read_a) begin
                pa = 1; due_a = e + LA - 1; free_a = e + LA + 2; ia = address_a[8:1];
            end
            if (!pb && e >= free_b && (read_b || write_b)) begin
                pb = 1; due_b = e + LB - 1; free_b = e + LB + 2; ib = address_b[8:1];
                wb = write_b; mb = wmask_b; db = wdata_b;
                if (read_b && write_b) exp_err_b = 1;
            end
            // Port A reads before port B's write is applied on a shared edge.
            if (pa && e == due_a) begin
                exp_resp_a = 1; exp_rd_a = mem_m[ia]; ka = mem_k[ia]; pa = 0;
            end
            if (pb && e == due_b) begin
                exp_resp_b = 1;
                if (!wb) begin
                    exp_rd_b = mem_m[ib]; kb = mem_k[ib];
                end else begin
                    if (mb[0]) mem_m[ib][7:0] = db[7:0];
                    if (mb[1]) mem_m[ib][15:8] = db[15:8];
                    if (mb == 2'b11) mem_k[ib] = 1;
                end
                pb = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("resp_a", {15'd0, resp_a}, {15'd0, exp_resp_a});
        chk("resp_b", {15'd0, resp_b}, {15'd0, exp_resp_b});
        chk("err_b", {15'd0, err_b}, {15'd0, exp_err_b});
        if (ka) chk("rdata_a", rdata_a, exp_rd_a);
        if (kb) chk("rdata_b", rdata_b, exp_rd_b);
    end

    // ---------------- driver tasks ----------------
    task automatic op_a(input logic [15:0] addr, output int lat, output logic [15:0] d);
        bit seen = 0;
        int t0;
        repeat (2) @(negedge clk);
        read_a = 1; address_a = addr; t0 = cyc;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_a) seen = 1;
        end
        lat = cyc - t0; d = rdata_a; read_a = 0;
        chk("resp_a_seen", {15'd0, seen}, 16'd1);
    endtask

    task automatic op_b(input bit rd, input bit wr, input logic [1:0] m, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat, output logic [15:0] d);
        bit seen = 0;
        int t0;
        repeat (2) @(negedge clk);
        read_b = rd; write_b = wr; wmask_b = m; address_b = addr; wdata_b = wd; t0 = cyc;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_b) seen = 1;
        end
        lat = cyc - t0; d = rdata_b; read_b = 0; write_b = 0;
        chk("resp_b_seen", {15'd0, seen}, 16'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          la, lb, npulse;
        int          pos [3];
        logic [15:0] d, dummy;

        repeat (3) @(negedge clk);
        rst_n = 1;

        // Basic write then read, latency and pulse width.
        op_b(0, 1, 2'b11, 16'h0010, 16'hBEEF, lb, dummy);
        chk("lat_b", 16'(lb), 16'd3);
        @(negedge clk);
        chk("resp_b_width", {15'd0, resp_b}, 16'd0);
        op_a(16'h0010, la, d);
        chk("lat_a", 16'(la), 16'd2);
        chk("rdata_a_beef", d, 16'hBEEF);

        // Byte masks.
        op_b(0, 1, 2'b11, 16'h0020, 16'h1234, lb, dummy);
        op_b(0, 1, 2'b10, 16'h0020, 16'hAB00, lb, dummy);
        op_b(1, 0, 2'b00, 16'h0020, 16'h0000, lb, d);
        chk("mask_10", d, 16'hAB34);
        op_b(0, 1, 2'b00, 16'h0020, 16'hFFFF, lb, dummy);
        chk("mask_00_lat", 16'(lb), 16'd3);
        op_b(1, 0, 2'b00, 16'h0020, 16'h0000, lb, d);
        chk("mask_00_data", d, 16'hAB34);

        // read_a held for 12 cycles: pulses at cycles 2, 6 and 10.
        repeat (2) @(negedge clk);
        read_a = 1; address_a = 16'h0020; npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (resp_a) begin
                if (npulse < 3) pos[npulse] = i;
                npulse++;
            end
        end
        read_a = 0;
        chk("held_count", 16'(npulse), 16'd3);
        chk("held_p0", 16'(pos[0]), 16'd2);
        chk("held_p1", 16'(pos[1]), 16'd6);
        chk("held_p2", 16'(pos[2]), 16'd10);

        // Address wrap and ignored bit 0.
        op_b(0, 1, 2'b11, 16'h0201, 16'h5A5A, lb, dummy);
        op_a(16'h0000, la, d);
        chk("wrap_a", d, 16'h5A5A);
        op_b(1, 0, 2'b00, 16'h0001, 16'h0000, lb, d);
        chk("wrap_b", d, 16'h5A5A);

        // Collision: B accepted one edge before A so that both commit on the
        // same edge (B latency 3, A latency 2).
        op_b(0, 1, 2'b11, 16'h0040, 16'h1111, lb, dummy);
        fork
            op_b(0, 1, 2'b11, 16'h0040, 16'h0F0F, lb, dummy);
            begin
                @(negedge clk);
                op_a(16'h0040, la, d);
            end
        join
        chk("collide_old", d, 16'h1111);
        op_a(16'h0040, la, d);
        chk("collide_new", d, 16'h0F0F);

        // Read and write both high: treated as a write, err_b sticky.
        op_b(1, 1, 2'b11, 16'h0030, 16'h4321, lb, dummy);
        chk("err_set", {15'd0, err_b}, 16'd1);
        op_a(16'h0030, la, d);
        chk("both_write", d, 16'h4321);
        chk("err_held", {15'd0, err_b}, 16'd1);

        // Reset in the middle of a port B write.
        repeat (2) @(negedge clk);
        write_b = 1; wmask_b = 2'b11; address_b = 16'h0010; wdata_b = 16'h7777;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_resp_b", {15'd0, resp_b}, 16'd0);
        chk("rst_err_b", {15'd0, err_b}, 16'd0);
        write_b = 0;
        @(negedge clk);
        rst_n = 1;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_b) npulse++;
        end
        chk("rst_no_pulse", 16'(npulse), 16'd0);
        op_a(16'h0010, la, d);
        chk("rst_mem_a", d, 16'hBEEF);
        op_b(1, 0, 2'b00, 16'h0010, 16'h0000, lb, d);
        chk("rst_mem_b", d, 16'hBEEF);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
